// File: rtl/cpu_ctrl_fsm_v2.sv
// Multicycle CPU control FSM: memory ready handshake with bus timeout, HALT, illegal-opcode trap.
// Optional retired-instruction counter enabled by defining CPU_CTRL_INSTR_COUNT_EN.
module cpu_ctrl_fsm_v2 #(
   parameter int unsigned OPC_W       = 5,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TO_W        = 8
`ifdef CPU_CTRL_INSTR_COUNT_EN
   ,parameter int unsigned CNT_W      = 32
`endif
) (
   input  logic             CLK,
   input  logic             resetn,
   input  logic [OPC_W-1:0] opcode,
   input  logic             run,
   input  logic             mem_ready,
   input  logic             clear_fault,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IR_EN,
   output logic             PC_EN,
   output logic             MDR_EN,
   output logic             BR_EN,
   output logic             RFwrite,
   output logic             LDW_EN,
   output logic             dataW_MDR,
   output logic             halted,
   output logic             fault,
   output logic [1:0]       fault_code,
`ifdef CPU_CTRL_INSTR_COUNT_EN
   output logic [CNT_W-1:0] instr_count,
`endif
   output logic [3:0]       state_o
);

   localparam int unsigned ST_W = 4;

   typedef enum logic [ST_W-1:0] {
      S_IDLE      = 4'd0,
      S_FETCH_MEM = 4'd1,
      S_FETCH_IR  = 4'd2,
      S_DECODE    = 4'd3,
      S_AR_ALU    = 4'd4,
      S_AR_ROUT   = 4'd5,
      S_LDW_MDR   = 4'd6,
      S_LDW_ROUT  = 4'd7,
      S_STW       = 4'd8,
      S_BR        = 4'd9,
      S_HALT      = 4'd10,
      S_FAULT     = 4'd11
   } state_e;

   state_e            state_q, state_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [1:0]        fault_code_q, fault_code_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              ir_en_q, ir_en_d;
   logic              br_en_q, br_en_d;
   logic              rf_write_q, rf_write_d;
   logic              ldw_en_q, ldw_en_d;
   logic              data_w_mdr_q, data_w_mdr_d;
   logic              halted_q, halted_d;
   logic              fault_q, fault_d;
   logic [31:0]       opc_val;
   logic              mem_wait;
   logic              timeout_hit;

   assign opc_val     = 32'(opcode);
   assign mem_wait    = (state_q == S_FETCH_MEM) || (state_q == S_LDW_MDR) || (state_q == S_STW);
   // Last permitted wait cycle; a simultaneous mem_ready takes priority over the fault.
   assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                        (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));

   // Next state, fault code and wait-cycle counter
   always_comb begin
      state_d      = state_q;
      fault_code_d = fault_code_q;
      to_cnt_d     = '0;
      case (state_q)
         S_IDLE:      if (run) state_d = S_FETCH_MEM;
         S_FETCH_MEM: begin
            if (mem_ready) state_d = S_FETCH_IR;
            else if (timeout_hit) begin
               state_d      = S_FAULT;
               fault_code_d = 2'b10;
            end
         end
         S_FETCH_IR:  state_d = S_DECODE;
         S_DECODE: begin
            if (opc_val <= 32'd16)      state_d = S_AR_ALU;
            else if (opc_val == 32'd17) state_d = S_BR;
            else if (opc_val == 32'd18) state_d = S_STW;
            else if (opc_val == 32'd19) state_d = S_LDW_MDR;
            else if (opc_val == 32'd20) state_d = S_HALT;
            else begin
               state_d      = S_FAULT;
               fault_code_d = 2'b01;
            end
         end
         S_AR_ALU:    state_d = S_AR_ROUT;
         S_AR_ROUT:   state_d = S_IDLE;
         S_LDW_MDR: begin
            if (mem_ready) state_d = S_LDW_ROUT;
            else if (timeout_hit) begin
               state_d      = S_FAULT;
               fault_code_d = 2'b10;
            end
         end
         S_LDW_ROUT:  state_d = S_IDLE;
         S_STW: begin
            if (mem_ready) state_d = S_IDLE;
            else if (timeout_hit) begin
               state_d      = S_FAULT;
               fault_code_d = 2'b10;
            end
         end
         S_BR:        state_d = S_IDLE;
         S_HALT:      if (clear_fault) state_d = S_IDLE;
         S_FAULT: begin
            if (clear_fault) begin
               state_d      = S_IDLE;
               fault_code_d = 2'b00;
            end
         end
         default:     state_d = S_IDLE;
      endcase
      // Counter is zero outside memory states, so every entry starts from zero.
      if (mem_wait && (state_d == state_q) && !mem_ready && (MEM_TIMEOUT != 0))
         to_cnt_d = to_cnt_q + TO_W'(1);
   end

   // Moore outputs decoded from the next state so the flops track the state register
   always_comb begin
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      ir_en_d      = 1'b0;
      br_en_d      = 1'b0;
      rf_write_d   = 1'b0;
      ldw_en_d     = 1'b0;
      data_w_mdr_d = 1'b0;
      halted_d     = 1'b0;
      fault_d      = 1'b0;
      case (state_d)
         S_FETCH_MEM: mem_read_d = 1'b1;
         S_FETCH_IR:  ir_en_d    = 1'b1;
         S_AR_ROUT:   rf_write_d = 1'b1;
         S_LDW_MDR: begin
            mem_read_d = 1'b1;
            ldw_en_d   = 1'b1;
         end
         S_LDW_ROUT: begin
            data_w_mdr_d = 1'b1;
            rf_write_d   = 1'b1;
         end
         S_STW: begin
            mem_write_d = 1'b1;
            ldw_en_d    = 1'b1;
         end
         S_BR:        br_en_d  = 1'b1;
         S_HALT:      halted_d = 1'b1;
         S_FAULT:     fault_d  = 1'b1;
         default:     ;
      endcase
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         to_cnt_q     <= '0;
         fault_code_q <= 2'b00;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         ir_en_q      <= 1'b0;
         br_en_q      <= 1'b0;
         rf_write_q   <= 1'b0;
         ldw_en_q     <= 1'b0;
         data_w_mdr_q <= 1'b0;
         halted_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         to_cnt_q     <= to_cnt_d;
         fault_code_q <= fault_code_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         ir_en_q      <= ir_en_d;
         br_en_q      <= br_en_d;
         rf_write_q   <= rf_write_d;
         ldw_en_q     <= ldw_en_d;
         data_w_mdr_q <= data_w_mdr_d;
         halted_q     <= halted_d;
         fault_q      <= fault_d;
      end
   end

`ifdef CPU_CTRL_INSTR_COUNT_EN
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic             retire;

   // Completed instructions retire on return to IDLE; HALT retires on entry.
   assign retire = ((state_d == S_IDLE) &&
                    ((state_q == S_AR_ROUT) || (state_q == S_LDW_ROUT) ||
                     (state_q == S_STW) || (state_q == S_BR))) ||
                   ((state_q == S_DECODE) && (state_d == S_HALT));

   always_comb begin
      instr_count_d = instr_count_q;
      if (retire) instr_count_d = instr_count_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) instr_count_q <= '0;
      else         instr_count_q <= instr_count_d;
   end

   assign instr_count = instr_count_q;
`endif

   // Address/data strobes are single pulses gated by the handshake
   assign PC_EN      = (state_q == S_FETCH_MEM) && mem_ready;
   assign MDR_EN     = (state_q == S_LDW_MDR) && mem_ready;
   assign MemRead    = mem_read_q;
   assign MemWrite   = mem_write_q;
   assign IR_EN      = ir_en_q;
   assign BR_EN      = br_en_q;
   assign RFwrite    = rf_write_q;
   assign LDW_EN     = ldw_en_q;
   assign dataW_MDR  = data_w_mdr_q;
   assign halted     = halted_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm_v2.sv
// Self-checking bench for cpu_ctrl_fsm_v2: directed and randomized instructions against
// an instruction-level expectation builder.
module tb_cpu_ctrl_fsm_v2;

   localparam int unsigned OPC_W = 5;
   localparam int unsigned TB_TO = 4;
   localparam int unsigned TO_W  = 8;
`ifdef CPU_CTRL_INSTR_COUNT_EN
   localparam int unsigned CNT_W = 3;
`endif

   localparam int ST_IDLE = 0, ST_FETCH_MEM = 1, ST_FETCH_IR = 2, ST_DECODE = 3,
                  ST_AR_ALU = 4, ST_AR_ROUT = 5, ST_LDW_MDR = 6, ST_LDW_ROUT = 7,
                  ST_STW = 8, ST_BR = 9, ST_HALT = 10, ST_FAULT = 11;

   logic CLK = 1'b0;
   logic resetn, run, mem_ready, clear_fault;
   logic [OPC_W-1:0] opcode;
   logic MemRead, MemWrite, IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite, LDW_EN, dataW_MDR;
   logic halted, fault;
   logic [1:0] fault_code;
   logic [3:0] state_o;
`ifdef CPU_CTRL_INSTR_COUNT_EN
   logic [CNT_W-1:0] instr_count;
`endif

   always #5 CLK = ~CLK;

   cpu_ctrl_fsm_v2 #(
      .OPC_W(OPC_W), .MEM_TIMEOUT(TB_TO), .TO_W(TO_W)
`ifdef CPU_CTRL_INSTR_COUNT_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .CLK(CLK), .resetn(resetn), .opcode(opcode), .run(run), .mem_ready(mem_ready),
      .clear_fault(clear_fault), .MemRead(MemRead), .MemWrite(MemWrite), .IR_EN(IR_EN),
      .PC_EN(PC_EN), .MDR_EN(MDR_EN), .BR_EN(BR_EN), .RFwrite(RFwrite), .LDW_EN(LDW_EN),
      .dataW_MDR(dataW_MDR), .halted(halted), .fault(fault), .fault_code(fault_code),
`ifdef CPU_CTRL_INSTR_COUNT_EN
      .instr_count(instr_count),
`endif
      .state_o(state_o)
   );

   logic [10:0] outs;
   assign outs = {MemRead, MemWrite, IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite, LDW_EN,
                  dataW_MDR, halted, fault};

   int checks   = 0;
   int failures = 0;
   int retired  = 0;

   int   q_st[$];
   bit   q_rdy[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Strobe pattern the datapath should see in a given state with a given mem_ready
   function automatic logic [10:0] exp_outs(input int s, input bit r);
      logic [10:0] o;
      o = '0;
      case (s)
         ST_FETCH_MEM: begin o[10] = 1'b1; o[7] = r; end
         ST_FETCH_IR:  o[8] = 1'b1;
         ST_AR_ROUT:   o[4] = 1'b1;
         ST_LDW_MDR:   begin o[10] = 1'b1; o[3] = 1'b1; o[6] = r; end
         ST_LDW_ROUT:  begin o[2] = 1'b1; o[4] = 1'b1; end
         ST_STW:       begin o[9] = 1'b1; o[3] = 1'b1; end
         ST_BR:        o[5] = 1'b1;
         ST_HALT:      o[1] = 1'b1;
         ST_FAULT:     o[0] = 1'b1;
         default:      ;
      endcase
      return o;
   endfunction

   task automatic chk_count(input string tag);
`ifdef CPU_CTRL_INSTR_COUNT_EN
      chk(tag, 32'(instr_count), 32'(retired % (1 << CNT_W)));
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   task automatic push(input int s, input bit r);
      q_st.push_back(s);
      q_rdy.push_back(r);
   endtask

   // A memory access: wait_n not-ready cycles then ready, or a timeout after TB_TO cycles
   task automatic push_mem(input int s, input int wait_n, output bit to);
      to = 1'b0;
      if (TB_TO != 0 && wait_n >= int'(TB_TO)) begin
         for (int i = 0; i < int'(TB_TO); i++) push(s, 1'b0);
         to = 1'b1;
      end else begin
         for (int i = 0; i < wait_n; i++) push(s, 1'b0);
         push(s, 1'b1);
      end
   endtask

   // Runs one instruction starting from IDLE; HALT/FAULT endings are held then cleared.
   task automatic run_instr(input int opc, input int fw, input int mw, input int hold);
      bit to;
      int endst;
      logic [1:0] ecode;
      bit counts;
      q_st.delete();
      q_rdy.delete();
      endst = ST_IDLE; ecode = 2'b00; counts = 1'b0;
      push(ST_IDLE, 1'($urandom_range(0, 1)));
      push_mem(ST_FETCH_MEM, fw, to);
      if (to) begin
         endst = ST_FAULT; ecode = 2'b10;
      end else begin
         push(ST_FETCH_IR, 1'($urandom_range(0, 1)));
         push(ST_DECODE, 1'($urandom_range(0, 1)));
         if (opc <= 16) begin
            push(ST_AR_ALU, 1'($urandom_range(0, 1)));
            push(ST_AR_ROUT, 1'($urandom_range(0, 1)));
            counts = 1'b1;
         end else if (opc == 17) begin
            push(ST_BR, 1'($urandom_range(0, 1)));
            counts = 1'b1;
         end else if (opc == 18) begin
            push_mem(ST_STW, mw, to);
            if (to) begin endst = ST_FAULT; ecode = 2'b10; end
            else counts = 1'b1;
         end else if (opc == 19) begin
            push_mem(ST_LDW_MDR, mw, to);
            if (to) begin endst = ST_FAULT; ecode = 2'b10; end
            else begin
               push(ST_LDW_ROUT, 1'($urandom_range(0, 1)));
               counts = 1'b1;
            end
         end else if (opc == 20) begin
            endst = ST_HALT; counts = 1'b1;
         end else begin
            endst = ST_FAULT; ecode = 2'b01;
         end
      end
      for (int i = 0; i < q_st.size(); i++) begin
         @(negedge CLK);
         if (i == 0) opcode = OPC_W'(opc);
         run         = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         mem_ready   = q_rdy[i];
         clear_fault = 1'($urandom_range(0, 1));
         #1;
         chk($sformatf("state op%0d c%0d", opc, i), 32'(state_o), 32'(q_st[i]));
         chk($sformatf("outs op%0d c%0d", opc, i), 32'(outs), 32'(exp_outs(q_st[i], q_rdy[i])));
         chk($sformatf("fcode op%0d c%0d", opc, i), 32'(fault_code), 32'd0);
         if (i == 0) chk_count($sformatf("count op%0d", opc));
      end
      if (counts) retired++;
      if (endst != ST_IDLE) begin
         for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            run = 1'b1; clear_fault = 1'b0; mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("hold state op%0d", opc), 32'(state_o), 32'(endst));
            chk($sformatf("hold outs op%0d", opc), 32'(outs), 32'(exp_outs(endst, 1'b0)));
            chk($sformatf("hold fcode op%0d", opc), 32'(fault_code), 32'(ecode));
            chk_count($sformatf("hold count op%0d", opc));
         end
         @(negedge CLK);
         clear_fault = 1'b1; run = 1'b1;
         #1;
         chk($sformatf("clr state op%0d", opc), 32'(state_o), 32'(endst));
      end
   endtask

   initial begin
      resetn = 1'b0; run = 1'b0; mem_ready = 1'b0; clear_fault = 1'b0; opcode = '0;
      repeat (2) @(negedge CLK);
      #1;
      chk("rst state", 32'(state_o), 32'd0);
      chk("rst outs", 32'(outs), 32'd0);
      chk("rst fcode", 32'(fault_code), 32'd0);
      chk_count("rst count");
      @(negedge CLK);
      resetn = 1'b1;
      repeat (2) begin
         @(negedge CLK);
         run = 1'b0; mem_ready = 1'b1; clear_fault = 1'b1;
         #1;
         chk("idle hold", 32'(state_o), 32'(ST_IDLE));
      end

      run_instr(0, 0, 0, 0);      // ADD, no waits
      run_instr(19, 0, 3, 0);     // LDW with three wait states
      run_instr(0, 4, 0, 3);      // fetch timeout
      run_instr(25, 0, 0, 3);     // illegal opcode
      run_instr(20, 0, 0, 10);    // HALT ignoring run
      run_instr(18, 3, 3, 0);     // ready on the last allowed cycle wins
      run_instr(18, 0, 4, 2);     // STW timeout
      run_instr(19, 1, 5, 2);     // LDW timeout
      run_instr(17, 0, 0, 0);     // BR
      run_instr(16, 2, 0, 0);     // EQ, last arithmetic opcode
      run_instr(21, 0, 0, 1);     // first illegal opcode

      // Reset in the middle of a store
      @(negedge CLK); opcode = OPC_W'(18); run = 1'b1; mem_ready = 1'b0; clear_fault = 1'b0;
      @(negedge CLK); mem_ready = 1'b1;
      @(negedge CLK); mem_ready = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      #1;
      chk("pre-rst state", 32'(state_o), 32'(ST_STW));
      chk("pre-rst MemWrite", 32'(MemWrite), 32'd1);
      #1 resetn = 1'b0;
      #1;
      retired = 0;
      chk("mid-rst MemWrite", 32'(MemWrite), 32'd0);
      chk("mid-rst state", 32'(state_o), 32'd0);
      chk("mid-rst outs", 32'(outs), 32'd0);
      chk_count("mid-rst count");
      @(negedge CLK);
      resetn = 1'b1; run = 1'b0;

      for (int n = 0; n < 9; n++) run_instr(n, 0, 0, 0);
      @(negedge CLK); run = 1'b0;
      #1;
`ifdef CPU_CTRL_INSTR_COUNT_EN
      chk("count wrap", 32'(instr_count), 32'd1);
`endif
      run_instr(30, 0, 0, 1);
      @(negedge CLK); run = 1'b0;
      #1;
`ifdef CPU_CTRL_INSTR_COUNT_EN
      chk("count after illegal", 32'(instr_count), 32'd1);
`endif

      for (int n = 0; n < 60; n++) begin
         int sel, opc, fw, mw;
         sel = int'($urandom_range(0, 9));
         case (sel)
            4:       opc = 17;
            5:       opc = 18;
            6:       opc = 19;
            7:       opc = 20;
            8:       opc = int'($urandom_range(21, 31));
            default: opc = int'($urandom_range(0, 16));
         endcase
         fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
         run_instr(opc, fw, mw, int'($urandom_range(1, 4)));
      end

      @(negedge CLK);
      run = 1'b0; clear_fault = 1'b0;
      #1;
      chk("final state", 32'(state_o), 32'(ST_IDLE));
      chk("final fcode", 32'(fault_code), 32'd0);
      chk_count("final count");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
